// File: rtl/executs_pkg.sv
// Shared encodings for the multiply/divide execution unit.
package executs_pkg;

  localparam int unsigned MD_OP_W = 3;

  // md_op encodings as presented by the decoder
  typedef enum logic [MD_OP_W-1:0] {
    MD_NOP   = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } md_op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the {acc, q} datapath: shift-add multiply or restoring divide.
module md_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Multiply: add multiplicand on q[0], shift {acc,q} right.
  // Divide: shift {acc,q} left, trial-subtract divisor, set quotient bit.
  // When the trial succeeds the true difference is below the divisor, so the
  // wrapped WIDTH-bit subtraction is exact.
  always_comb begin
    sum     = q_i[0] ? ({1'b0, acc_i} + {1'b0, opnd_i}) : {1'b0, acc_i};
    shifted = {acc_i, q_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    diff    = shifted[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      acc_o = ge ? diff : shifted[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], ge};
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/executs_md.sv
// Sequential multiply/divide unit with architectural HI/LO and busy/done handshake.
module executs_md
  import executs_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   Read_data_1,
  input  logic [WIDTH-1:0]   Read_data_2,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   Hi_out,
  output logic [WIDTH-1:0]   Lo_out
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_q;

  md_op_e             op;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  md_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .q_o      (step_q)
  );

  assign op = md_op_e'(md_op);

  // Next-state, operand latching, iteration and sign fix-up
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    opnd_d    = opnd_q;
    rs_d      = rs_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = signed_op && Read_data_1[WIDTH-1];
    b_neg     = signed_op && Read_data_2[WIDTH-1];
    a_mag     = a_neg ? (WIDTH'(0) - Read_data_1) : Read_data_1;
    b_mag     = b_neg ? (WIDTH'(0) - Read_data_2) : Read_data_2;
    prod      = neg_res_q ? ((2*WIDTH)'(0) - {acc_q, q_q}) : {acc_q, q_q};
    quot      = neg_res_q ? (WIDTH'(0) - q_q) : q_q;
    rem       = neg_rem_q ? (WIDTH'(0) - acc_q) : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            MD_MTHI: hi_d = Read_data_1;
            MD_MTLO: lo_d = Read_data_1;
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              div_d     = (op == MD_DIV) || (op == MD_DIVU);
              acc_d     = '0;
              cnt_d     = '0;
              rs_d      = Read_data_1;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              dz_d      = (Read_data_2 == '0);
              if ((op == MD_DIV) || (op == MD_DIVU)) begin
                q_d    = a_mag;
                opnd_d = b_mag;
              end else begin
                q_d    = b_mag;
                opnd_d = a_mag;
              end
              state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIN: begin
        if (!div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        done_d  = 1'b1;
        dbz_d   = div_q && dz_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over completion; HI/LO are left untouched
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      opnd_q    <= '0;
      rs_q      <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      opnd_q    <= opnd_d;
      rs_q      <= rs_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign Hi_out      = hi_q;
  assign Lo_out      = lo_q;

endmodule
